// File: rtl/iterative_alu_exec_if.sv
// Request/response bundle between issue, the iterative execute ALU and writeback/branch logic.
interface iterative_alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_ctrl, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/iterative_alu_exec.sv
// Execute-stage ALU, one operation in flight; shifts step one bit per cycle unless
// FAST_SHIFT_EN is defined, which swaps in a single-cycle barrel shifter.
module iterative_alu_exec #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  iterative_alu_exec_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLL  = 4'b0101;
  localparam logic [3:0] C_SRL  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_SLT  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;

`ifdef FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rdy;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic [XLEN-1:0] w_res;
  logic            w_accept;
  logic            w_load_res;

`ifndef FAST_SHIFT_EN
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [3:0]      r_sh_ctrl;
  logic [SHW-1:0]  w_amt;
  logic            w_load_acc;

  assign w_amt = bus.src_b[SHW-1:0];
`endif

  function automatic logic f_is_shift(input logic [3:0] c);
    f_is_shift = (c == C_SLL) || (c == C_SRL) || (c == C_SRA);
  endfunction

  // Single-cycle result; in the iterative build shift codes only arrive here with amount 0.
  function automatic logic [XLEN-1:0] f_alu(input logic [3:0]      c,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
`ifdef FAST_SHIFT_EN
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
`endif
    sa = a;
    sb = b;
    case (c)
      C_SUB:  f_alu = a - b;
      C_AND:  f_alu = a & b;
      C_OR:   f_alu = a | b;
      C_XOR:  f_alu = a ^ b;
`ifdef FAST_SHIFT_EN
      C_SLL:  f_alu = a << sh;
      C_SRL:  f_alu = a >> sh;
      C_SRA:  f_alu = sa >>> sh;
`else
      C_SLL,
      C_SRL,
      C_SRA:  f_alu = a;
`endif
      C_SLT:  f_alu = {{(XLEN-1){1'b0}}, (sa < sb)};
      C_SLTU: f_alu = {{(XLEN-1){1'b0}}, (a < b)};
      default: f_alu = a + b;
    endcase
  endfunction

`ifndef FAST_SHIFT_EN
  function automatic logic [XLEN-1:0] f_shift1(input logic [3:0]      c,
                                               input logic [XLEN-1:0] v);
    case (c)
      C_SLL:   f_shift1 = {v[XLEN-2:0], 1'b0};
      C_SRL:   f_shift1 = {1'b0, v[XLEN-1:1]};
      C_SRA:   f_shift1 = {v[XLEN-1], v[XLEN-1:1]};
      default: f_shift1 = v;
    endcase
  endfunction
`endif

  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.in_ready  = r_rdy && (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_load_res  = 1'b0;
    w_res       = f_alu(bus.alu_ctrl, bus.src_a, bus.src_b);
`ifndef FAST_SHIFT_EN
    w_load_acc  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifndef FAST_SHIFT_EN
          if (f_is_shift(bus.alu_ctrl) && (w_amt != '0)) begin
            w_load_acc  = 1'b1;
            w_state_nxt = SHIFT;
          end else begin
            w_load_res  = 1'b1;
            w_state_nxt = DONE;
          end
`else
          w_load_res  = 1'b1;
          w_state_nxt = DONE;
`endif
        end
      end
`ifndef FAST_SHIFT_EN
      // The last step's shifted value goes straight into the result register.
      SHIFT: begin
        if (r_cnt == SHW'(1)) begin
          w_res       = f_shift1(r_sh_ctrl, r_acc);
          w_load_res  = 1'b1;
          w_state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_rdy keeps in_ready low during reset and opens it one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rdy    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
`ifndef FAST_SHIFT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= 1'b1;
      if (w_load_res) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
      end
`ifndef FAST_SHIFT_EN
      if (w_load_acc) begin
        r_cnt <= w_amt;
      end else if (r_state == SHIFT) begin
        r_cnt <= r_cnt - SHW'(1);
      end
`endif
    end
  end

`ifndef FAST_SHIFT_EN
  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_acc     <= bus.src_a;
      r_sh_ctrl <= bus.alu_ctrl;
    end else if (r_state == SHIFT) begin
      r_acc <= f_shift1(r_sh_ctrl, r_acc);
    end
  end
`endif
endmodule

// File: tb/tb_iterative_alu_exec.sv
// Directed bench for iterative_alu_exec: hand-computed vectors plus an arithmetic reference model.
`timescale 1ns/1ps
module tb_iterative_alu_exec;
  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iterative_alu_exec_if #(.XLEN(XLEN)) bus ();
  iterative_alu_exec #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          n_tests  = 0;
  int          n_fail   = 0;
  logic        armed    = 1'b0;
  logic [31:0] exp_res  = '0;
  logic        exp_zero = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned k;
    k = b % 32;
    case (c)
      4'd1:    model = a - b;
      4'd2:    model = a & b;
      4'd3:    model = a | b;
      4'd4:    model = a ^ b;
      4'd5:    model = a << k;
      4'd6:    model = a >> k;
      4'd7:    model = $signed(a) >>> k;
      4'd8:    model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    model = (a < b) ? 32'd1 : 32'd0;
      default: model = a + b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef FAST_SHIFT_EN
    exp_lat = 1;
`else
    if (c >= 4'd5 && c <= 4'd7) exp_lat = 1 + int'(b % 32);
    else                        exp_lat = 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && armed && bus.out_valid) begin
      check("model_result", bus.result, exp_res);
      check("model_zero", bus.zero, exp_zero);
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) check("in_ready_wait", bus.in_ready, 1);
    exp_res      = model(c, a, b);
    exp_zero     = (exp_res == 32'd0);
    armed        = 1'b1;
    bus.alu_ctrl = c;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.src_a    = ~a;
    bus.src_b    = ~b;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("hs_out_valid_drop", bus.out_valid, 0);
    check("hs_in_ready_back", bus.in_ready, 1);
  endtask

  task automatic run(input string name, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit);
    int lat;
    issue(c, a, b, lat);
    check({name, "_lat"}, lat, exp_lat(c, b));
    check({name, "_res"}, bus.result, lit);
    check({name, "_zero"}, bus.zero, (lit == 32'd0));
    finish_op();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_ctrl  = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", bus.in_ready, 1);

    run("add_ovf",   4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    run("sub_zero",  4'd1, 32'd5,         32'd5,         32'h0000_0000);
    run("sub_wrap",  4'd1, 32'd0,         32'd1,         32'hFFFF_FFFF);
    run("and",       4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    run("or",        4'd3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0);
    run("xor",       4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    run("sra4",      4'd7, 32'h8000_0000, 32'd4,         32'hF800_0000);
    run("sra3_pos",  4'd7, 32'h7FFF_FFFF, 32'd3,         32'h0FFF_FFFF);
    run("srl4",      4'd6, 32'hF000_0000, 32'd4,         32'h0F00_0000);
    run("srl_hi",    4'd6, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000);
    run("sll0",      4'd5, 32'h1234_5678, 32'd0,         32'h1234_5678);
    run("sll32",     4'd5, 32'd5,         32'd32,        32'h0000_0005);
    run("sll31",     4'd5, 32'd1,         32'd31,        32'h8000_0000);
    run("slt",       4'd8, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001);
    run("sltu",      4'd9, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000);
    run("code_f",    4'hF, 32'd2,         32'd3,         32'h0000_0005);
    run("code_a",    4'hA, 32'd10,        32'd20,        32'h0000_001E);

    // Backpressure: result must hold and new requests be ignored while DONE.
    issue(4'd0, 32'd1, 32'd2, lat);
    check("bp_lat", lat, 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 4'd1;
      bus.src_a    = 32'd100;
      bus.src_b    = 32'd1;
      @(posedge clk);
      #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_result", bus.result, 32'd3);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    finish_op();

    // Reset in the middle of a long shift.
    @(negedge clk);
    exp_res      = model(4'd6, 32'hFFFF_FFFF, 32'd20);
    exp_zero     = 1'b0;
    bus.alu_ctrl = 4'd6;
    bus.src_a    = 32'hFFFF_FFFF;
    bus.src_b    = 32'd20;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("ms_busy_in_ready", bus.in_ready, 0);
`ifndef FAST_SHIFT_EN
    check("ms_busy_out_valid", bus.out_valid, 0);
`endif
    rst_n = 1'b0;
    #1;
    check("ms_rst_out_valid", bus.out_valid, 0);
    check("ms_rst_result", bus.result, 0);
    check("ms_rst_zero", bus.zero, 0);
    check("ms_rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst_add", 4'd0, 32'd1, 32'd1, 32'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
